serial_parity_receiver: RTL and testbench

//  Serial-to-parallel receiver for the 7-bit + parity serial link driven by the parity shift transmitter.

---
 rtl/serial_parity_receiver_pkg.sv | 16 +
 rtl/serial_parity_receiver_sat_counter.sv | 21 ++
 rtl/serial_parity_receiver.sv | 85 ++++++++
 tb/tb_serial_parity_receiver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/serial_parity_receiver_pkg.sv
// Constants shared by the parity serial link: FSM states, default frame width
// and parity modes. The transmitter uses the same values.
package serial_parity_receiver_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 7;
    localparam int DEFAULT_ERR_WIDTH  = 8;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_receiver_sat_counter.sv
// Saturating up-counter. A clear wins over an increment on the same edge,
// and the count holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int ERR_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_WIDTH-1:0] count
);

    always_ff @(posedge Clock) begin
        if (!Resetn || clr) begin
            count <= '0;
        end else if (inc && (count != {ERR_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_parity_receiver.sv
// Receives LSB-first frames of DATA_WIDTH data bits plus one parity bit,
// presents the word with a one-cycle Valid and counts parity failures.
//
// state | meaning
// IDLE  | waiting for Start; serialInput is ignored
// RECV  | frame in progress; bitCount data bits captured so far
module serial_parity_receiver
    import serial_parity_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit ODD_PARITY = PARITY_EVEN,
    parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic                  serialInput,
    input  logic                  ClearErr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  Valid,
    output logic                  ParityError,
    output logic                  Busy,
    output logic [2:0]            bitCount,
    output logic [ERR_WIDTH-1:0]  errorCount
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_acc;
    logic                  parity_cycle;
    logic                  parity_bad;

    // The parity bit is on the line when a full word is captured and no new
    // Start is aborting the frame.
    assign parity_cycle = (state == RECV) && !Start && (bitCount == LAST_BIT);
    assign parity_bad   = parity_acc ^ serialInput ^ ODD_PARITY;
    assign Busy         = (state == RECV);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= IDLE;
            shift_reg   <= '0;
            parity_acc  <= 1'b0;
            bitCount    <= '0;
            data        <= '0;
            Valid       <= 1'b0;
            ParityError <= 1'b0;
        end else begin
            Valid       <= 1'b0;
            ParityError <= 1'b0;
            if (Start) begin
                // Start always begins a fresh frame, abandoning any partial one.
                shift_reg  <= {{(DATA_WIDTH-1){1'b0}}, serialInput};
                parity_acc <= serialInput;
                bitCount   <= 3'd1;
                state      <= RECV;
            end else if (state == RECV) begin
                if (bitCount != LAST_BIT) begin
                    shift_reg[bitCount] <= serialInput;
                    parity_acc          <= parity_acc ^ serialInput;
                    bitCount            <= bitCount + 3'd1;
                end else begin
                    data        <= shift_reg;
                    Valid       <= 1'b1;
                    ParityError <= parity_bad;
                    bitCount    <= '0;
                    state       <= IDLE;
                end
            end
        end
    end

    sat_counter #(
        .ERR_WIDTH (ERR_WIDTH)
    ) u_err_count (
        .Clock  (Clock),
        .Resetn (Resetn),
        .inc    (parity_cycle && parity_bad),
        .clr    (ClearErr),
        .count  (errorCount)
    );

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Directed bench for serial_parity_receiver with hand-computed expectations.
module tb_serial_parity_receiver;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start;
    logic       serialInput;
    logic       ClearErr;
    logic [6:0] data;
    logic       Valid;
    logic       ParityError;
    logic       Busy;
    logic [2:0] bitCount;
    logic [7:0] errorCount;

    int n_checks = 0;
    int n_errors = 0;

    serial_parity_receiver dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .serialInput (serialInput),
        .ClearErr    (ClearErr),
        .data        (data),
        .Valid       (Valid),
        .ParityError (ParityError),
        .Busy        (Busy),
        .bitCount    (bitCount),
        .errorCount  (errorCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set between edges; outputs are read 1ns after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Start plus the first n data bits of w.
    task automatic drive_bits(input logic [6:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            Start       = (i == 0);
            serialInput = w[i];
            tick();
            check("no_valid_mid", Valid, 1'b0);
        end
        Start = 1'b0;
    endtask

    task automatic drive_frame(input logic [6:0] w, input logic p, input logic clr);
        drive_bits(w, 7);
        serialInput = p;
        ClearErr    = clr;
        tick();
        ClearErr    = 1'b0;
        serialInput = 1'b0;
        check("valid_strobe", Valid, 1'b1);
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; serialInput = 1'b0; ClearErr = 1'b0;

        // 1: reset with inputs toggling
        Start = 1'b1; serialInput = 1'b1; tick();
        Start = 1'b0; serialInput = 1'b0; tick();
        check("rst_data", data, 7'h00);
        check("rst_valid", Valid, 1'b0);
        check("rst_perr", ParityError, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_bitcount", bitCount, 3'd0);
        check("rst_errcount", errorCount, 8'd0);
        Resetn = 1'b1;
        tick();
        check("idle_busy", Busy, 1'b0);

        // 2: good even-parity frame 7'h53
        Start = 1'b1; serialInput = 1'b1; tick();
        Start = 1'b0;
        check("first_bitcount", bitCount, 3'd1);
        check("first_busy", Busy, 1'b1);
        for (int i = 1; i < 7; i++) begin
            serialInput = (7'h53 >> i) & 1'b1;
            tick();
        end
        check("full_bitcount", bitCount, 3'd7);
        serialInput = 1'b0; tick();
        check("g_valid", Valid, 1'b1);
        check("g_data", data, 7'h53);
        check("g_perr", ParityError, 1'b0);
        check("g_errcount", errorCount, 8'd0);
        check("g_busy", Busy, 1'b0);
        check("g_bitcount", bitCount, 3'd0);
        tick();
        check("g_valid_drop", Valid, 1'b0);
        check("g_data_hold", data, 7'h53);

        // 3: bad parity, then saturation
        drive_frame(7'h53, 1'b1, 1'b0);
        check("b_perr", ParityError, 1'b1);
        check("b_errcount", errorCount, 8'd1);
        tick();
        check("b_perr_drop", ParityError, 1'b0);
        for (int k = 0; k < 300; k++) begin
            drive_frame(7'h53, 1'b1, 1'b0);
            if (k == 253) check("sat_reach", errorCount, 8'd255);
        end
        check("sat_hold", errorCount, 8'd255);

        ClearErr = 1'b1; tick(); ClearErr = 1'b0;
        check("clr_errcount", errorCount, 8'd0);

        // 4: abort at bitCount=4, restart with 7'h7F
        drive_bits(7'h15, 4);
        check("abort_bitcount", bitCount, 3'd4);
        drive_frame(7'h7F, 1'b1, 1'b0);
        check("abort_data", data, 7'h7F);
        check("abort_perr", ParityError, 1'b0);
        check("abort_errcount", errorCount, 8'd0);

        // 5: back-to-back frames, second Start during Valid
        drive_frame(7'h01, 1'b1, 1'b0);
        check("b2b_data1", data, 7'h01);
        check("b2b_perr1", ParityError, 1'b0);
        drive_frame(7'h00, 1'b0, 1'b0);
        check("b2b_data2", data, 7'h00);
        check("b2b_perr2", ParityError, 1'b0);
        check("b2b_errcount", errorCount, 8'd0);

        // 6: reset mid-frame, then recovery and clear-vs-error priority
        drive_bits(7'h2A, 3);
        check("mid_bitcount", bitCount, 3'd3);
        Resetn = 1'b0; serialInput = 1'b1; tick();
        check("mid_rst_valid", Valid, 1'b0);
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_bitcount", bitCount, 3'd0);
        check("mid_rst_data", data, 7'h00);
        Resetn = 1'b1; serialInput = 1'b0; tick();
        check("post_rst_valid", Valid, 1'b0);
        drive_frame(7'h2A, 1'b1, 1'b0);
        check("rec_data", data, 7'h2A);
        check("rec_perr", ParityError, 1'b0);
        drive_frame(7'h2A, 1'b0, 1'b0);
        check("pre_clr_errcount", errorCount, 8'd1);
        drive_frame(7'h2A, 1'b0, 1'b1);
        check("clr_win_perr", ParityError, 1'b1);
        check("clr_win_errcount", errorCount, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
